// File: rtl/relu_lane_scheduler_pkg.sv
// Shared types and constants for the serial ReLU lane scheduler.
// Data type, FSM state encoding and requester indices.
package relu_lane_scheduler_pkg;

   localparam int DATA_W = 16;

   typedef logic signed [DATA_W-1:0] data_type;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_RUN    = 2'd1;
   localparam state_t ST_DRAIN1 = 2'd2;
   localparam state_t ST_DRAIN2 = 2'd3;

   localparam int REQ_FWD = 0;
   localparam int REQ_BWD = 1;

   localparam logic MODE_FWD = 1'b0;
   localparam logic MODE_BWD = 1'b1;

endpackage

// File: rtl/relu_lane_scheduler_lane.sv
// Registered single-element ReLU lane, latency one cycle.
// Forward passes non-negative z; backward gates da by z > 0.
module relu_lane #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mode,
   input  logic                     in_valid,
   input  logic [ADDR_W-1:0]        addr,
   input  logic signed [DATA_W-1:0] z,
   input  logic signed [DATA_W-1:0] da,
   output logic                     out_valid,
   output logic [ADDR_W-1:0]        out_addr,
   output logic signed [DATA_W-1:0] out_data
);

   import relu_lane_scheduler_pkg::*;

   localparam logic signed [DATA_W-1:0] ZERO = '0;

   logic signed [DATA_W-1:0] res;

   // Element arithmetic; z == 0 yields 0 in both modes.
   always_comb begin
      res = ZERO;
      if (mode == MODE_BWD) begin
         if (z > ZERO) res = da;
      end else begin
         if (!(z < ZERO)) res = z;
      end
   end

   // Output register; data is zeroed when no element is in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= in_valid;
         out_addr  <= addr;
         out_data  <= in_valid ? res : ZERO;
      end
   end

endmodule

// File: rtl/relu_lane_scheduler.sv
// Shares one serial ReLU lane between forward and backward requesters.
// Round-robin arbiter, address walk FSM and read-data alignment stage.
module relu_lane_scheduler #(
   parameter int M      = 5,
   parameter int DATA_W = 16,
   parameter int ADDR_W = $clog2(M)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   output logic [1:0]        gnt,
   output logic [1:0]        ack,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] z_rdata,
   input  logic [DATA_W-1:0] da_rdata,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_sel
);

   import relu_lane_scheduler_pkg::*;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(M - 1);

   state_t            state;
   logic              last_bwd;
   logic [1:0]        pick;
   logic              rd_vld;
   logic [ADDR_W-1:0] rd_addr_q;
   logic signed [DATA_W-1:0] lane_data;

   // Arbiter: a lone request wins; on contention the one not served last wins.
   always_comb begin
      pick = 2'b00;
      unique case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = last_bwd ? 2'b01 : 2'b10;
         default: pick = 2'b00;
      endcase
   end

   // Job FSM, read address walk, grant/ack and read-valid alignment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         last_bwd  <= 1'b1;
         gnt       <= 2'b00;
         ack       <= 2'b00;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         wr_sel    <= 1'b0;
         rd_vld    <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         ack       <= 2'b00;
         rd_vld    <= rd_en;
         rd_addr_q <= rd_addr;
         case (state)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  state    <= ST_RUN;
                  gnt      <= pick;
                  wr_sel   <= pick[REQ_BWD];
                  last_bwd <= pick[REQ_BWD];
                  rd_en    <= 1'b1;
                  rd_addr  <= '0;
               end
            end
            ST_RUN: begin
               if (rd_addr == LAST) begin
                  state   <= ST_DRAIN1;
                  rd_en   <= 1'b0;
                  rd_addr <= '0;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            ST_DRAIN1: begin
               state <= ST_DRAIN2;
               ack   <= gnt;
            end
            ST_DRAIN2: begin
               state  <= ST_IDLE;
               gnt    <= 2'b00;
               wr_sel <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

   relu_lane #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .mode      (wr_sel),
      .in_valid  (rd_vld),
      .addr      (rd_addr_q),
      .z         (z_rdata),
      .da        (da_rdata),
      .out_valid (wr_en),
      .out_addr  (wr_addr),
      .out_data  (lane_data)
   );

   assign wr_data = lane_data;

endmodule

// File: tb/tb_relu_lane_scheduler.sv
// Self-checking bench for relu_lane_scheduler with a buffer model.
// Directed and random jobs compared against a per-cycle reference.
module tb_relu_lane_scheduler;

   localparam int M  = 5;
   localparam int DW = 16;
   localparam int AW = $clog2(M);

   logic          clk;
   logic          reset;
   logic [1:0]    req;
   logic [1:0]    gnt;
   logic [1:0]    ack;
   logic          busy;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] z_rdata;
   logic [DW-1:0] da_rdata;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_sel;

   logic signed [DW-1:0] zbuf [M];
   logic signed [DW-1:0] dabuf [M];

   int total = 0;
   int bad   = 0;

   relu_lane_scheduler #(.M(M), .DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .gnt      (gnt),
      .ack      (ack),
      .busy     (busy),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .z_rdata  (z_rdata),
      .da_rdata (da_rdata),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_sel   (wr_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector buffers: registered read, data one cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en && rd_addr < AW'(M)) begin
         z_rdata  <= zbuf[rd_addr];
         da_rdata <= dabuf[rd_addr];
      end
   end

   task automatic chk(input string tag, input int t,
                      input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_val(input int g, input int i);
      int zi;
      int r;
      zi = zbuf[i];
      r = 0;
      if (g == 0) r = (zi < 0) ? 0 : zi;
      else        r = (zi > 0) ? int'(dabuf[i]) : 0;
      return DW'(r);
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_gnt"},   0, 32'(gnt),     0);
      chk({tag, "_ack"},   0, 32'(ack),     0);
      chk({tag, "_busy"},  0, 32'(busy),    0);
      chk({tag, "_rden"},  0, 32'(rd_en),   0);
      chk({tag, "_raddr"}, 0, 32'(rd_addr), 0);
      chk({tag, "_wren"},  0, 32'(wr_en),   0);
      chk({tag, "_waddr"}, 0, 32'(wr_addr), 0);
      chk({tag, "_wdata"}, 0, 32'(wr_data), 0);
      chk({tag, "_wsel"},  0, 32'(wr_sel),  0);
   endtask

   task automatic check_cycle(input int g, input int t);
      logic [1:0] oh;
      logic       in_job;
      oh = (g == 1) ? 2'b10 : 2'b01;
      in_job = (t >= 1 && t <= M + 2);
      chk("busy", t, 32'(busy), 32'(in_job));
      chk("gnt",  t, 32'(gnt),  in_job ? 32'(oh) : 0);
      chk("ack",  t, 32'(ack),  (t == M + 2) ? 32'(oh) : 0);
      chk("rd_en", t, 32'(rd_en), 32'(t >= 1 && t <= M));
      if (t >= 1 && t <= M)
         chk("rd_addr", t, 32'(rd_addr), 32'(t - 1));
      chk("wr_en", t, 32'(wr_en), 32'(t >= 3 && t <= M + 2));
      if (in_job)
         chk("wr_sel", t, 32'(wr_sel), 32'(g));
      if (t >= 3 && t <= M + 2) begin
         chk("wr_addr", t, 32'(wr_addr), 32'(t - 3));
         chk("wr_data", t, 32'(wr_data), 32'(ref_val(g, t - 3)));
      end
   endtask

   // Caller drives req during cycle 0; task observes cycles 1..M+3.
   task automatic run_job(input int g, input int drop_at,
                          input logic [1:0] drop_val, input int abort_at,
                          input logic [1:0] end_req);
      for (int t = 1; t <= M + 3; t++) begin
         @(posedge clk);
         @(negedge clk);
         check_cycle(g, t);
         if (t == drop_at) req = drop_val;
         if (t == M + 2) req = end_req;
         if (t == abort_at) begin
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_zero("abort");
            reset = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      reset    = 1'b0;
      req      = 2'b00;
      z_rdata  = '0;
      da_rdata = '0;
      for (int i = 0; i < M; i++) begin
         zbuf[i]  = '0;
         dabuf[i] = '0;
      end

      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;

      zbuf[0] = -16'sd3; zbuf[1] = 16'sd0; zbuf[2] = 16'sd7;
      zbuf[3] = -16'sd1; zbuf[4] = 16'sd12;
      for (int i = 0; i < M; i++) dabuf[i] = DW'(5 + i);

      req = 2'b01;
      run_job(0, 0, 2'b00, 0, 2'b00);
      req = 2'b10;
      run_job(1, 0, 2'b00, 0, 2'b00);

      zbuf[0] = -16'sd32768; zbuf[1] = 16'sd32767; zbuf[2] = -16'sd1;
      zbuf[3] = 16'sd1;      zbuf[4] = 16'sd0;
      for (int i = 0; i < M; i++) dabuf[i] = 16'sd100;
      req = 2'b01;
      run_job(0, 0, 2'b00, 0, 2'b00);
      req = 2'b10;
      run_job(1, 0, 2'b00, 0, 2'b00);

      req   = 2'b11;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_zero("rst2");
      reset = 1'b1;
      run_job(0, 0, 2'b00, 0, 2'b11);
      run_job(1, 0, 2'b00, 0, 2'b11);
      run_job(0, 0, 2'b00, 0, 2'b00);

      for (int k = 0; k < 6; k++) begin
         int g;
         for (int i = 0; i < M; i++) begin
            zbuf[i]  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            dabuf[i] = DW'($urandom);
         end
         g = int'($urandom_range(0, 1));
         req = (g == 1) ? 2'b10 : 2'b01;
         run_job(g, 0, 2'b00, 0, 2'b00);
      end

      req = 2'b01;
      run_job(0, 3, 2'b00, 0, 2'b00);
      @(posedge clk);
      @(negedge clk);
      chk("drop_idle_busy", 0, 32'(busy), 0);
      chk("drop_idle_rden", 0, 32'(rd_en), 0);

      req = 2'b10;
      run_job(1, 0, 2'b00, 0, 2'b11);
      run_job(0, 0, 2'b00, 4, 2'b11);
      run_job(0, 0, 2'b00, 0, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/relu_lane_scheduler.md
Name: relu_lane_scheduler

Overview:
- Shares one serial ReLU lane between two requesters: forward pass (req 0, a = max(0,z)) and backward pass (req 1, dz = z>0 ? da : 0).
- Each granted job walks an M-element vector: reads z (and da) from the layer vector buffers, computes one element per cycle and writes the result back.
- Sits between the layer-level training controller and the vector buffers. It replaces the M-wide parallel activation registers when area matters.

Parameters:
- M, 5, vector length (rows), M >= 2.
- DATA_W, 16, width of data_type (signed fixed-point).
- ADDR_W, $clog2(M), element address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- req  in  2  job request; bit0 forward, bit1 backward; level, held until ack
- gnt  out  2  one-hot grant, high from first read cycle through ack cycle
- ack  out  2  one-cycle done pulse for the granted requester
- busy  out  1  high whenever state != IDLE
- rd_en  out  1  vector buffer read strobe
- rd_addr  out  ADDR_W  element index being read
- z_rdata  in  DATA_W  z element, valid 1 cycle after rd_en
- da_rdata  in  DATA_W  upstream gradient element, valid 1 cycle after rd_en; ignored in forward jobs
- wr_en  out  1  result write strobe
- wr_addr  out  ADDR_W  element index being written
- wr_data  out  DATA_W  result element
- wr_sel  out  1  0 = activation buffer (a), 1 = gradient buffer (dz)

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, priority pointer to req0. All outputs are 0: gnt, ack, busy, rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_sel. Reset mid-job aborts the job without ack; in-flight writes are dropped.
- FSM states: IDLE -> RUN -> DRAIN1 -> DRAIN2 -> IDLE.
- IDLE, cycle 0: if req != 0, arbitrate and go to RUN.
  - Only one bit set: that requester wins.
  - Both bits set: round-robin. The requester not granted last wins. After reset, req0 wins.
  - The pointer updates when the grant is taken.
- RUN, cycles 1..M: rd_en=1, rd_addr=0..M-1, incremented each cycle. After rd_addr==M-1, go to DRAIN1.
- DRAIN1, cycle M+1: rd_en=0. Go to DRAIN2.
- DRAIN2, cycle M+2: last write. ack[g]=1 for exactly this cycle. Go to IDLE.
- Cycle M+3: IDLE. The next job can be sampled in this cycle, so its first read is at M+4.
- Pipeline: read at cycle t, rdata sampled at t+1, registered write at t+2. wr_en is high for cycles 3..M+2, with wr_addr = rd_addr delayed by 2. Total job latency is M+3 cycles from the cycle req is sampled.
- Lane arithmetic, signed compare on DATA_W:
  - Forward: z<0 -> 0, else z.
  - Backward: z<=0 -> 0, else da. z==0 gives 0 in both modes.
- wr_sel = g, held for the whole job. gnt holds the same value from cycle 1 through cycle M+2.
- Requests are sampled only in IDLE.
  - A req dropping mid-job does not abort the job; the job completes and acks.
  - The other requester's req arriving mid-job waits.
- No back-pressure: buffers accept one read and one write per cycle.

Decomposition:
- Shared package / typedef.vh: data_type (signed DATA_W), DATA_W, state enum {IDLE,RUN,DRAIN1,DRAIN2}, REQ_FWD=0 / REQ_BWD=1 constants.
- Sub-module relu_lane: registered single-element compute.
  - Inputs: clk, reset, mode, in_valid, addr, z, da.
  - Outputs: out_valid, out_addr, out_data.
  - Latency 1.
- The scheduler holds the FSM, arbiter, address counter and 1-cycle read-valid/address delay.

Test Plan:
- Reset, then req=01 at cycle 0, z={-3,0,7,-1,12} (M=5) -> reads cycles 1..5; wr_en cycles 3..7 with wr_data {0,0,7,0,12}, wr_sel=0; ack[0] at cycle 7 only; busy cycles 1..7.
- req=10, same z, da={5,6,7,8,9} -> wr_data {0,0,7,0,9}, wr_sel=1, ack[1] at cycle 7.
- req=11 held continuously from reset -> job order fwd, bwd, fwd. Each job is 8 cycles incl. IDLE; second job's first rd_en is 1 cycle after first job's IDLE.
- Boundary values: z={-32768,32767,-1,1,0}, fwd -> {0,32767,0,1,0}; bwd with da all 100 -> {0,100,0,100,0}.
- req0 dropped at cycle 3 of a forward job -> job still writes all 5 elements and pulses ack[0]; no new job starts.
- reset asserted at cycle 4 of a job -> next cycle all outputs 0, no ack; after release, req=11 grants req0 first.
